// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch, LSU and debug port (req/gnt/rvalid).
// Debug access is compiled in only when MEM_ARB_DEBUG_PORT_EN is defined.
module mem_port_arbiter #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    DBG_ADDR_WIDTH = 15,
   parameter logic [ADDR_WIDTH-1:0] DBG_BASE       = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   input  logic                    data_req_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   input  logic                    debug_req_i,
   input  logic                    debug_we_i,
   input  logic [DBG_ADDR_WIDTH-1:0] debug_addr_i,
   input  logic [DATA_WIDTH-1:0]   debug_wdata_i,
   output logic                    debug_gnt_o,
   output logic                    debug_rvalid_o,
   output logic [DATA_WIDTH-1:0]   debug_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                    arb_busy_o
);

   typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA, OWN_DEBUG} owner_t;

   owner_t owner_q, owner_d;
   logic   we_q, we_d;
   logic   ptr_data_q, ptr_data_d;
   logic   dbg_req;
   logic [ADDR_WIDTH-1:0] dbg_ext, dbg_sum, dbg_addr;
   logic [DATA_WIDTH-1:0] resp_rdata;

   // Debug wins outright; instr/data alternate via the pointer. Nothing is granted in reset.
   always_comb begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      debug_gnt_o = 1'b0;
      if (!rst_i) begin
         if (dbg_req)
            debug_gnt_o = 1'b1;
         else if (instr_req_i && (!data_req_i || !ptr_data_q))
            instr_gnt_o = 1'b1;
         else if (data_req_i)
            data_gnt_o = 1'b1;
      end
   end

   always_comb begin
      dbg_ext = '0;
      dbg_ext[DBG_ADDR_WIDTH-1:0] = debug_addr_i;
   end
   assign dbg_sum  = DBG_BASE + dbg_ext;
   assign dbg_addr = {dbg_sum[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (debug_gnt_o) begin
         mem_we_o    = debug_we_i;
         mem_be_o    = '1;
         mem_addr_o  = dbg_addr;
         mem_wdata_o = debug_wdata_i;
      end else if (instr_gnt_o) begin
         mem_be_o    = '1;
         mem_addr_o  = instr_addr_i;
      end else if (data_gnt_o) begin
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_addr_o  = data_addr_i;
         mem_wdata_o = data_wdata_i;
      end
   end
   assign mem_req_o = instr_gnt_o | data_gnt_o | debug_gnt_o;

   always_comb begin
      owner_d    = OWN_NONE;
      we_d       = 1'b0;
      ptr_data_d = ptr_data_q;
      if (instr_gnt_o) begin
         owner_d    = OWN_INSTR;
         ptr_data_d = 1'b1;
      end else if (data_gnt_o) begin
         owner_d    = OWN_DATA;
         we_d       = data_we_i;
         ptr_data_d = 1'b0;
      end else if (debug_gnt_o) begin
         owner_d    = OWN_DEBUG;
         we_d       = debug_we_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q    <= OWN_NONE;
         we_q       <= 1'b0;
         ptr_data_q <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         we_q       <= we_d;
         ptr_data_q <= ptr_data_d;
      end
   end

   // Responses are masked while reset is held so a discarded access never surfaces.
   assign resp_rdata     = we_q ? '0 : mem_rdata_i;
   assign instr_rvalid_o = !rst_i && (owner_q == OWN_INSTR);
   assign data_rvalid_o  = !rst_i && (owner_q == OWN_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? resp_rdata : '0;
   assign data_rdata_o   = data_rvalid_o ? resp_rdata : '0;

`ifdef MEM_ARB_DEBUG_PORT_EN
   assign dbg_req        = debug_req_i;
   assign debug_rvalid_o = !rst_i && (owner_q == OWN_DEBUG);
   assign debug_rdata_o  = debug_rvalid_o ? resp_rdata : '0;
`else
   logic unused_debug_req;
   assign unused_debug_req = debug_req_i;
   assign dbg_req          = 1'b0;
   assign debug_rvalid_o   = 1'b0;
   assign debug_rdata_o    = '0;
`endif

   assign arb_busy_o = instr_req_i | data_req_i | dbg_req | (owner_q != OWN_NONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; debug-port steps follow MEM_ARB_DEBUG_PORT_EN.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req = 1'b0;
   logic [31:0] instr_addr = '0;
   logic        instr_gnt, instr_rvalid;
   logic [31:0] instr_rdata;
   logic        data_req = 1'b0, data_we = 1'b0;
   logic [3:0]  data_be = '0;
   logic [31:0] data_addr = '0, data_wdata = '0;
   logic        data_gnt, data_rvalid;
   logic [31:0] data_rdata;
   logic        debug_req = 1'b0, debug_we = 1'b0;
   logic [14:0] debug_addr = '0;
   logic [31:0] debug_wdata = '0;
   logic        debug_gnt, debug_rvalid;
   logic [31:0] debug_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        arb_busy;

   int passed = 0;
   int total  = 0;

   mem_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
      .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
      .debug_req_i(debug_req), .debug_we_i(debug_we), .debug_addr_i(debug_addr),
      .debug_wdata_i(debug_wdata), .debug_gnt_o(debug_gnt),
      .debug_rvalid_o(debug_rvalid), .debug_rdata_o(debug_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .arb_busy_o(arb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      instr_req = 1'b0; data_req = 1'b0; debug_req = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      // reset state, with a request present while reset is held
      next_cycle();
      instr_req = 1'b1; instr_addr = 32'h10;
      settle();
      chk("rst_instr_gnt", instr_gnt, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_instr_rvalid", instr_rvalid, 0);
      chk("rst_data_rvalid", data_rvalid, 0);
      chk("rst_debug_rvalid", debug_rvalid, 0);

      // 1: lone fetch
      next_cycle();
      rst = 1'b0;
      settle();
      chk("t1_instr_gnt", instr_gnt, 1);
      chk("t1_data_gnt", data_gnt, 0);
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'h10);
      chk("t1_mem_we", mem_we, 0);
      chk("t1_mem_be", mem_be, 4'hF);
      chk("t1_busy", arb_busy, 1);
      next_cycle();
      instr_req = 1'b0; mem_rdata = 32'hDEADBEEF;
      settle();
      chk("t1_instr_rvalid", instr_rvalid, 1);
      chk("t1_instr_rdata", instr_rdata, 32'hDEADBEEF);
      chk("t1_data_rvalid", data_rvalid, 0);
      chk("t1_data_rdata", data_rdata, 0);
      chk("t1_mem_req_idle", mem_req, 0);
      // pointer now prefers DATA
      next_cycle();
      instr_req = 1'b1; data_req = 1'b1; data_addr = 32'h40;
      settle();
      chk("t1_ptr_data_gnt", data_gnt, 1);
      chk("t1_ptr_instr_gnt", instr_gnt, 0);

      // 2: continuous instr+data from reset alternate I,D,I,D
      do_reset();
      for (int k = 0; k < 4; k++) begin
         instr_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
         mem_rdata = 32'h1000 + k;
         settle();
         chk("t2_instr_gnt", instr_gnt, (k % 2) == 0);
         chk("t2_data_gnt", data_gnt, (k % 2) == 1);
         chk("t2_mem_req", mem_req, 1);
         if (k > 0) begin
            chk("t2_instr_rvalid", instr_rvalid, (k % 2) == 1);
            chk("t2_data_rvalid", data_rvalid, (k % 2) == 0);
            if (k % 2 == 1) chk("t2_instr_rdata", instr_rdata, 32'h1000 + k);
            else            chk("t2_data_rdata", data_rdata, 32'h1000 + k);
         end
         next_cycle();
      end
      instr_req = 1'b0; data_req = 1'b0; mem_rdata = 32'h2004;
      settle();
      chk("t2_last_data_rvalid", data_rvalid, 1);
      chk("t2_last_data_rdata", data_rdata, 32'h2004);
      chk("t2_last_instr_rvalid", instr_rvalid, 0);

      // 3: LSU partial write
      next_cycle();
      data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
      data_addr = 32'h100; data_wdata = 32'h1234_5678;
      settle();
      chk("t3_data_gnt", data_gnt, 1);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_be", mem_be, 4'b0011);
      chk("t3_mem_addr", mem_addr, 32'h100);
      chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
      next_cycle();
      data_req = 1'b0; data_we = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      settle();
      chk("t3_data_rvalid", data_rvalid, 1);
      chk("t3_data_rdata", data_rdata, 0);

`ifdef MEM_ARB_DEBUG_PORT_EN
      // 4: debug beats both core ports; pointer (INSTR) untouched
      next_cycle();
      instr_req = 1'b1; instr_addr = 32'h20; data_req = 1'b1; data_addr = 32'h80;
      debug_req = 1'b1; debug_we = 1'b0; debug_addr = 15'h7FFF;
      settle();
      chk("t4_debug_gnt", debug_gnt, 1);
      chk("t4_instr_gnt", instr_gnt, 0);
      chk("t4_data_gnt", data_gnt, 0);
      chk("t4_mem_addr", mem_addr, 32'h0000_7FFC);
      chk("t4_mem_be", mem_be, 4'hF);
      next_cycle();
      debug_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
      settle();
      chk("t4_debug_rvalid", debug_rvalid, 1);
      chk("t4_debug_rdata", debug_rdata, 32'hCAFE_F00D);
      chk("t4_instr_gnt_after", instr_gnt, 1);
      chk("t4_mem_addr_after", mem_addr, 32'h20);
      next_cycle();
      instr_req = 1'b0; mem_rdata = 32'h5555_AAAA;
      settle();
      chk("t4_data_gnt_after", data_gnt, 1);
      chk("t4_instr_rvalid", instr_rvalid, 1);
      chk("t4_debug_rvalid_gone", debug_rvalid, 0);
      next_cycle();
      data_req = 1'b0;
`else
      // 6: debug port compiled out
      next_cycle();
      instr_req = 1'b1; instr_addr = 32'h20; debug_req = 1'b1; debug_addr = 15'h0100;
      settle();
      chk("t6_instr_gnt", instr_gnt, 1);
      chk("t6_debug_gnt", debug_gnt, 0);
      chk("t6_mem_addr", mem_addr, 32'h20);
      next_cycle();
      instr_req = 1'b0; mem_rdata = 32'h7777_0001;
      settle();
      chk("t6_instr_rvalid", instr_rvalid, 1);
      chk("t6_debug_rvalid", debug_rvalid, 0);
      chk("t6_debug_rdata", debug_rdata, 0);
      chk("t6_debug_gnt_hold", debug_gnt, 0);
      next_cycle();
      debug_req = 1'b0;
`endif

      // 5: reset right after a grant discards the response
      instr_req = 1'b1; instr_addr = 32'h44;
      settle();
      chk("t5_instr_gnt", instr_gnt, 1);
      next_cycle();
      rst = 1'b1; instr_req = 1'b0; mem_rdata = 32'h0BAD_0BAD;
      settle();
      chk("t5_rvalid_in_rst", instr_rvalid, 0);
      chk("t5_rdata_in_rst", instr_rdata, 0);
      chk("t5_mem_req_in_rst", mem_req, 0);
      next_cycle();
      rst = 1'b0;
      settle();
      chk("t5_rvalid_after", instr_rvalid, 0);
      chk("t5_busy_after", arb_busy, 0);
      chk("t5_mem_req_after", mem_req, 0);
      next_cycle();
      settle();
      chk("t5_rvalid_later", instr_rvalid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
